rf_writeback_unit: RTL and testbench
====================================

Name: rf_writeback_unit

Overview:
- Writer side of the register-file write port: accepts retiring instructions from execute and drives the regfile write interface (wdata, waddr, wen, valid).
- ALU results commit directly; load results wait for memory read data, which is byte/half extracted and sign/zero extended before commit.
- Sits between EXU/LSU and the register file. Emits exactly one o_valid pulse per retired instruction, which feeds the regfile's valid input.

Parameters:
- ADDR_WIDTH, 5, register index width (4 for RV32E builds).
- DATA_WIDTH, 32, datapath width. Load formatting is defined for 32 only.

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  unit can accept an instruction this cycle.
- i_rd  in  ADDR_WIDTH  destination register.
- i_wen  in  1  instruction writes rd.
- i_is_load  in  1  result comes from memory.
- i_funct3  in  3  load type.
- i_addr_lo  in  2  load address bits [1:0].
- i_result  in  DATA_WIDTH  ALU/CSR result; ignored for loads.
- i_mem_rvalid  in  1  memory read data valid.
- i_mem_rdata  in  DATA_WIDTH  raw aligned memory word.
- o_waddr  out  ADDR_WIDTH  regfile write address.
- o_wdata  out  DATA_WIDTH  regfile write data.
- o_wen  out  1  regfile write enable.
- o_valid  out  1  one-cycle retire pulse.
- o_pending  out  1  a load is outstanding.
- o_pending_rd  out  ADDR_WIDTH  rd of the outstanding load; 0 when none.

Behaviour:
- Reset: asynchronous on i_reset_n low. State = IDLE; o_valid, o_wen, o_pending = 0; o_waddr, o_wdata, o_pending_rd = 0.
- Reset asserted mid-WAIT_MEM aborts the load: no commit occurs, and a later i_mem_rvalid in IDLE is ignored.
- FSM states: IDLE, WAIT_MEM.
- o_ready = 1 only in IDLE.
- Handshake: an instruction is accepted when i_valid && o_ready at a clock edge.
- IDLE, accept non-load:
  - Next cycle o_valid = 1, o_waddr = i_rd, o_wdata = i_result, o_wen = i_wen && (i_rd != 0).
  - FSM stays in IDLE. Throughput is one instruction per cycle, latency 1.
- IDLE, accept load:
  - Capture rd, wen, funct3, addr_lo; go to WAIT_MEM.
  - Next cycle o_pending = 1, o_pending_rd = rd.
- WAIT_MEM:
  - Hold until i_mem_rvalid = 1. At that edge, register the formatted data, pulse o_valid, go to IDLE, clear o_pending.
  - Load-to-commit latency is 1 cycle after rvalid.
  - i_mem_rvalid in the accept cycle itself is ignored.
- Load formatting (byte lane b = addr_lo, half lane h = addr_lo[1]):
  - 000 LB: sign-extend byte b.
  - 001 LH: sign-extend half h.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte b.
  - 101 LHU: zero-extend half h.
  - Any other value: full word.
  - addr_lo[0] is ignored for halfwords; no misalignment trap is raised.
- o_valid / o_wen are each high for exactly one cycle per retire. Both are 0 in all other cycles.
- o_waddr / o_wdata hold their last value when o_valid = 0.
- rd = 0 or i_wen = 0: o_valid still pulses, o_wen = 0.
- i_mem_rvalid while in IDLE is ignored.

Optional Feature:
- Macro: RF_WB_FORWARD_EN.
- Defined: adds ports i_raddr1 and i_raddr2 (ADDR_WIDTH, in) and o_rdata1_fwd and o_rdata2_fwd (DATA_WIDTH, out), plus o_fwd_hit1 and o_fwd_hit2 (1, out).
  - o_fwd_hitN = o_valid && o_wen && (i_raddrN == o_waddr), combinational.
  - o_rdataN_fwd = o_wdata when the hit is 1, else 0.
  - This covers same-cycle read-after-write while the regfile is updating.
- Undefined: none of these ports exist; no forwarding logic is built.

Test Plan:
- Reset, then ALU rd = 5, result 0x12345678 -> next cycle o_valid = 1, o_wen = 1, o_waddr = 5, o_wdata = 0x12345678; o_valid low the cycle after.
- Back-to-back ALU instructions rd = 1 then rd = 2 on consecutive cycles -> o_ready stays 1; o_valid pulses on two consecutive cycles with matching addr/data.
- LB rd = 3, addr_lo = 2, rvalid after 3 cycles with rdata 0x00_80_00_00:
  - o_ready = 0 and o_pending = 1 with o_pending_rd = 3 while waiting.
  - Commit o_wdata = 0xFFFFFF80.
- LHU addr_lo = 2 with rdata 0xBEEF1234 -> 0x0000BEEF. LW -> 0xBEEF1234.
- ALU rd = 0, result 0xFFFFFFFF -> o_valid = 1, o_wen = 0.
- Load accepted, i_reset_n pulsed low for 1 cycle, then i_mem_rvalid -> no o_valid pulse; state IDLE, o_pending = 0, o_ready = 1.

Source files
------------

// File: rtl/rf_writeback_unit_if.sv
// Bundle of the writeback unit's upstream, memory-return and regfile-write signals.
// The unit uses the slave modport; the driving side uses master.
// Optional RF_WB_FORWARD_EN adds same-cycle read forwarding signals.
interface rf_writeback_unit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic [ADDR_WIDTH-1:0] i_rd;
  logic                  i_wen;
  logic                  i_is_load;
  logic [2:0]            i_funct3;
  logic [1:0]            i_addr_lo;
  logic [DATA_WIDTH-1:0] i_result;
  logic                  i_mem_rvalid;
  logic [DATA_WIDTH-1:0] i_mem_rdata;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic                  o_wen;
  logic                  o_valid;
  logic                  o_pending;
  logic [ADDR_WIDTH-1:0] o_pending_rd;
`ifdef RF_WB_FORWARD_EN
  logic [ADDR_WIDTH-1:0] i_raddr1;
  logic [ADDR_WIDTH-1:0] i_raddr2;
  logic [DATA_WIDTH-1:0] o_rdata1_fwd;
  logic [DATA_WIDTH-1:0] o_rdata2_fwd;
  logic                  o_fwd_hit1;
  logic                  o_fwd_hit2;
`endif

  modport slave (
    input  i_valid, i_rd, i_wen, i_is_load, i_funct3, i_addr_lo, i_result,
           i_mem_rvalid, i_mem_rdata,
`ifdef RF_WB_FORWARD_EN
    input  i_raddr1, i_raddr2,
    output o_rdata1_fwd, o_rdata2_fwd, o_fwd_hit1, o_fwd_hit2,
`endif
    output o_ready, o_waddr, o_wdata, o_wen, o_valid, o_pending, o_pending_rd
  );

  modport master (
    output i_valid, i_rd, i_wen, i_is_load, i_funct3, i_addr_lo, i_result,
           i_mem_rvalid, i_mem_rdata,
`ifdef RF_WB_FORWARD_EN
    output i_raddr1, i_raddr2,
    input  o_rdata1_fwd, o_rdata2_fwd, o_fwd_hit1, o_fwd_hit2,
`endif
    input  o_ready, o_waddr, o_wdata, o_wen, o_valid, o_pending, o_pending_rd
  );
endinterface

// File: rtl/rf_writeback_unit.sv
// Register-file writeback unit: ALU results retire one cycle after acceptance,
// loads park in WAIT_MEM until memory data returns, then are lane-extracted,
// extended and retired one cycle after i_mem_rvalid.
// Optional macro RF_WB_FORWARD_EN builds same-cycle read forwarding of the
// value being written this cycle.
module rf_writeback_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic                 i_clock,
  input logic                 i_reset_n,
  rf_writeback_unit_if.slave  bus
);

  typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

  // Everything needed to finish a load once memory answers.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic                  wen;
    logic [2:0]            f3;
    logic [1:0]            lo;
  } ld_t;

  state_t                state_q, state_d;
  ld_t                   ld_q, ld_d;
  logic                  pending_q, pending_d;
  logic                  valid_q, valid_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  // Byte lane = addr_lo, half lane = addr_lo[1]; unknown funct3 passes the word.
  function automatic logic [DATA_WIDTH-1:0] fmt_load(
    input logic [2:0]            f3,
    input logic [1:0]            lo,
    input logic [DATA_WIDTH-1:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  fmt_load = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  fmt_load = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  fmt_load = {{(DATA_WIDTH-16){1'b0}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Next-state: accept in IDLE, retire ALU ops at once, loads on memory return.
  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    pending_d = pending_q;
    valid_d   = 1'b0;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          if (bus.i_is_load) begin
            state_d   = WAIT_MEM;
            ld_d      = '{rd: bus.i_rd, wen: bus.i_wen, f3: bus.i_funct3, lo: bus.i_addr_lo};
            pending_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            waddr_d = bus.i_rd;
            wdata_d = bus.i_result;
            wen_d   = bus.i_wen && (bus.i_rd != '0);
          end
        end
      end
      WAIT_MEM: begin
        if (bus.i_mem_rvalid) begin
          state_d   = IDLE;
          pending_d = 1'b0;
          valid_d   = 1'b1;
          waddr_d   = ld_q.rd;
          wdata_d   = fmt_load(ld_q.f3, ld_q.lo, bus.i_mem_rdata);
          wen_d     = ld_q.wen && (ld_q.rd != '0);
          ld_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any load in flight.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      ld_q      <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.o_ready      = (state_q == IDLE);
  assign bus.o_valid      = valid_q;
  assign bus.o_wen        = wen_q;
  assign bus.o_waddr      = waddr_q;
  assign bus.o_wdata      = wdata_q;
  assign bus.o_pending    = pending_q;
  assign bus.o_pending_rd = pending_q ? ld_q.rd : '0;

`ifdef RF_WB_FORWARD_EN
  // Forward the word the regfile is absorbing this cycle to its read ports.
  assign bus.o_fwd_hit1   = valid_q && wen_q && (bus.i_raddr1 == waddr_q);
  assign bus.o_fwd_hit2   = valid_q && wen_q && (bus.i_raddr2 == waddr_q);
  assign bus.o_rdata1_fwd = bus.o_fwd_hit1 ? wdata_q : '0;
  assign bus.o_rdata2_fwd = bus.o_fwd_hit2 ? wdata_q : '0;
`endif

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed bench for rf_writeback_unit: expected retires are queued when an
// instruction (or memory return) is driven and checked when o_valid pulses.
module tb_rf_writeback_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ntests = 0;
  int   nfail = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        w;
  } exp_t;
  exp_t q[$];

  rf_writeback_unit_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus();

  rf_writeback_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Retire monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_retire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("retire_waddr", {27'd0, bus.o_waddr}, {27'd0, e.a});
        chk("retire_wdata", bus.o_wdata, e.d);
        chk("retire_wen", {31'd0, bus.o_wen}, {31'd0, e.w});
      end
    end else begin
      chk("idle_wen_low", {31'd0, bus.o_wen}, 32'd0);
    end
  end

  task automatic alu(input logic [4:0] rd, input logic wen, input logic [31:0] res);
    chk("alu_ready", {31'd0, bus.o_ready}, 32'd1);
    bus.i_valid   = 1'b1;
    bus.i_is_load = 1'b0;
    bus.i_rd      = rd;
    bus.i_wen     = wen;
    bus.i_result  = res;
    q.push_back('{a: rd, d: res, w: wen && (rd != 5'd0)});
    tick();
    bus.i_valid   = 1'b0;
    chk("alu_valid_next", {31'd0, bus.o_valid}, 32'd1);
  endtask

  // Load with `dly` wait cycles before memory answers; a stray rvalid in the
  // accept cycle and a blocked ALU request while waiting must both be ignored.
  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                      input logic [31:0] rdata, input int dly, input logic [31:0] exp);
    bus.i_valid      = 1'b1;
    bus.i_is_load    = 1'b1;
    bus.i_rd         = rd;
    bus.i_wen        = 1'b1;
    bus.i_funct3     = f3;
    bus.i_addr_lo    = lo;
    bus.i_result     = 32'hCAFEF00D;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hDEADBEEF;
    tick();
    bus.i_is_load    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    for (int i = 0; i < dly; i++) begin
      chk("wait_ready", {31'd0, bus.o_ready}, 32'd0);
      chk("wait_pending", {31'd0, bus.o_pending}, 32'd1);
      chk("wait_pending_rd", {27'd0, bus.o_pending_rd}, {27'd0, rd});
      chk("wait_no_valid", {31'd0, bus.o_valid}, 32'd0);
      tick();
    end
    bus.i_valid      = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = rdata;
    q.push_back('{a: rd, d: exp, w: (rd != 5'd0)});
    tick();
    bus.i_mem_rvalid = 1'b0;
    chk("load_commit_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("load_pending_clr", {31'd0, bus.o_pending}, 32'd0);
    chk("load_pending_rd_clr", {27'd0, bus.o_pending_rd}, 32'd0);
    chk("load_ready_back", {31'd0, bus.o_ready}, 32'd1);
  endtask

  initial begin
    bus.i_valid      = 1'b0;
    bus.i_rd         = '0;
    bus.i_wen        = 1'b0;
    bus.i_is_load    = 1'b0;
    bus.i_funct3     = '0;
    bus.i_addr_lo    = '0;
    bus.i_result     = '0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
`ifdef RF_WB_FORWARD_EN
    bus.i_raddr1     = 5'd5;
    bus.i_raddr2     = 5'd6;
`endif
    tick();
    tick();
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_wen", {31'd0, bus.o_wen}, 32'd0);
    chk("rst_pending", {31'd0, bus.o_pending}, 32'd0);
    chk("rst_waddr", {27'd0, bus.o_waddr}, 32'd0);
    chk("rst_wdata", bus.o_wdata, 32'd0);
    chk("rst_pending_rd", {27'd0, bus.o_pending_rd}, 32'd0);
    chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Single ALU retire, then pulse must drop while addr/data hold.
    alu(5'd5, 1'b1, 32'h12345678);
`ifdef RF_WB_FORWARD_EN
    chk("fwd_hit1", {31'd0, bus.o_fwd_hit1}, 32'd1);
    chk("fwd_rdata1", bus.o_rdata1_fwd, 32'h12345678);
    chk("fwd_hit2", {31'd0, bus.o_fwd_hit2}, 32'd0);
    chk("fwd_rdata2", bus.o_rdata2_fwd, 32'd0);
`endif
    tick();
    chk("alu_valid_drop", {31'd0, bus.o_valid}, 32'd0);
    chk("hold_waddr", {27'd0, bus.o_waddr}, 32'd5);
    chk("hold_wdata", bus.o_wdata, 32'h12345678);

    // Back-to-back ALU ops.
    alu(5'd1, 1'b1, 32'h11111111);
    alu(5'd2, 1'b1, 32'h22222222);
    tick();

    // rd = 0 and i_wen = 0 still pulse valid without a write.
    alu(5'd0, 1'b1, 32'hFFFFFFFF);
    alu(5'd7, 1'b0, 32'h0BADF00D);
    tick();

    // Load formatting.
    load(5'd3, 3'b000, 2'd2, 32'h00800000, 3, 32'hFFFFFF80);  // LB
    load(5'd4, 3'b101, 2'd2, 32'hBEEF1234, 1, 32'h0000BEEF);  // LHU
    load(5'd6, 3'b010, 2'd1, 32'hBEEF1234, 0, 32'hBEEF1234);  // LW
    load(5'd8, 3'b001, 2'd3, 32'h80010000, 2, 32'hFFFF8001);  // LH, lo[0] ignored
    load(5'd9, 3'b100, 2'd1, 32'h0000AB00, 1, 32'h000000AB);  // LBU
    load(5'd10, 3'b011, 2'd0, 32'h87654321, 1, 32'h87654321); // other -> word
    load(5'd0, 3'b010, 2'd0, 32'h55555555, 1, 32'h55555555);  // rd 0, no write
    tick();

    // Reset mid-WAIT_MEM aborts the load; later rvalid is ignored.
    bus.i_valid   = 1'b1;
    bus.i_is_load = 1'b1;
    bus.i_rd      = 5'd12;
    bus.i_funct3  = 3'b010;
    tick();
    bus.i_valid   = 1'b0;
    bus.i_is_load = 1'b0;
    chk("abort_pending_before", {31'd0, bus.o_pending}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h13572468;
    tick();
    bus.i_mem_rvalid = 1'b0;
    tick();
    chk("abort_no_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("abort_pending", {31'd0, bus.o_pending}, 32'd0);
    chk("abort_ready", {31'd0, bus.o_ready}, 32'd1);

    tick();
    tick();
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
